// File: rtl/adder_result_checker.sv
// adder_result_checker: response side of the adder test harness. Samples {Cin,B,A}
// and both adder results, scores them against the golden A+B+Cin over one exhaustive
// sweep locked to the stimulus counter wrap, and reports counts and a verdict.
// Optional build macro ADDER_CHK_HALT_ON_ERR_EN: the first mismatch ends the sweep.
module adder_result_checker #(
   parameter int unsigned W     = 4,
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             restart,
   input  logic [W-1:0]     A,
   input  logic [W-1:0]     B,
   input  logic             Cin,
   input  logic [W-1:0]     sum_l,
   input  logic             cout_l,
   input  logic [W-1:0]     sum_r,
   input  logic             cout_r,
   output logic [ERR_W-1:0] err_l,
   output logic [ERR_W-1:0] err_r,
   output logic [2*W:0]     fail_vec,
   output logic             fail_seen,
   output logic             busy,
   output logic             done,
   output logic             pass
);
   localparam int unsigned VW = 2*W + 1;
   localparam int unsigned CW = 2*W + 2;
   localparam int unsigned SW = W + 1;
   localparam logic [CW-1:0]    LAST_VEC = CW'((1 << VW) - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic            valid_s1_q;
   logic [VW-1:0]   v_s1_q;
   logic [SW-1:0]   sl_s1_q, sr_s1_q;
   logic [SW-1:0]   exp_s1;
   logic            valid_s2_q, mis_l_s2_q, mis_r_s2_q;
   logic [VW-1:0]   v_s2_q;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    vec_cnt_q, vec_cnt_d;
   logic [ERR_W-1:0] err_l_q, err_l_d, err_r_q, err_r_d;
   logic [VW-1:0]    fail_vec_q, fail_vec_d;
   logic             fail_seen_q, fail_seen_d;
   logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic             mis_any;

   // Stage S1: capture operands and both adder results when qualified
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_s1_q <= 1'b0;
         v_s1_q     <= '0;
         sl_s1_q    <= '0;
         sr_s1_q    <= '0;
      end else begin
         valid_s1_q <= en;
         if (en) begin
            v_s1_q  <= {Cin, B, A};
            sl_s1_q <= {cout_l, sum_l};
            sr_s1_q <= {cout_r, sum_r};
         end
      end
   end

   // Golden sum at full W+1 width
   assign exp_s1 = SW'(v_s1_q[W-1:0]) + SW'(v_s1_q[2*W-1:W]) + SW'(v_s1_q[2*W]);

   // Stage S2: register per-adder mismatch flags alongside the vector
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_s2_q <= 1'b0;
         v_s2_q     <= '0;
         mis_l_s2_q <= 1'b0;
         mis_r_s2_q <= 1'b0;
      end else begin
         valid_s2_q <= valid_s1_q;
         v_s2_q     <= v_s1_q;
         mis_l_s2_q <= (sl_s1_q != exp_s1);
         mis_r_s2_q <= (sr_s1_q != exp_s1);
      end
   end

   assign mis_any = mis_l_s2_q | mis_r_s2_q;

   // Sweep FSM: arm on v==0, score every valid S2 sample, hold results in DONE
   always_comb begin
      state_d     = state_q;
      vec_cnt_d   = vec_cnt_q;
      err_l_d     = err_l_q;
      err_r_d     = err_r_q;
      fail_vec_d  = fail_vec_q;
      fail_seen_d = fail_seen_q;
      if (restart) begin
         state_d     = ST_IDLE;
         vec_cnt_d   = '0;
         err_l_d     = '0;
         err_r_d     = '0;
         fail_vec_d  = '0;
         fail_seen_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (valid_s1_q && (v_s1_q == '0)) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (valid_s2_q) begin
                  vec_cnt_d = vec_cnt_q + CW'(1);
                  if (mis_l_s2_q && (err_l_q != ERR_MAX)) err_l_d = err_l_q + ERR_W'(1);
                  if (mis_r_s2_q && (err_r_q != ERR_MAX)) err_r_d = err_r_q + ERR_W'(1);
                  if (!fail_seen_q && mis_any) begin
                     fail_vec_d  = v_s2_q;
                     fail_seen_d = 1'b1;
                  end
                  if (vec_cnt_q == LAST_VEC) state_d = ST_DONE;
`ifdef ADDER_CHK_HALT_ON_ERR_EN
                  if (mis_any) state_d = ST_DONE;
`endif
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
      pass_d = done_d && (err_l_d == '0) && (err_r_d == '0);
   end

   // State, scoreboard and registered status outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         vec_cnt_q   <= '0;
         err_l_q     <= '0;
         err_r_q     <= '0;
         fail_vec_q  <= '0;
         fail_seen_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_cnt_q   <= vec_cnt_d;
         err_l_q     <= err_l_d;
         err_r_q     <= err_r_d;
         fail_vec_q  <= fail_vec_d;
         fail_seen_q <= fail_seen_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

   assign err_l     = err_l_q;
   assign err_r     = err_r_q;
   assign fail_vec  = fail_vec_q;
   assign fail_seen = fail_seen_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker: drives counter sweeps with injected adder faults into
// adder_result_checker and checks it every cycle against a transaction-level model.
// Expectations follow ADDER_CHK_HALT_ON_ERR_EN when that macro is defined.
module tb_adder_result_checker;
   localparam int ERR_MAX = 255;
   localparam int NVEC    = 512;

   logic       clk = 1'b0;
   logic       reset, en, restart;
   logic [3:0] A, B, sum_l, sum_r;
   logic       Cin, cout_l, cout_r;
   logic [7:0] err_l, err_r;
   logic [8:0] fail_vec;
   logic       fail_seen, busy, done, pass;

   always #5 clk = ~clk;

   adder_result_checker #(.W(4), .ERR_W(8)) dut (
      .clk(clk), .reset(reset), .en(en), .restart(restart),
      .A(A), .B(B), .Cin(Cin),
      .sum_l(sum_l), .cout_l(cout_l), .sum_r(sum_r), .cout_r(cout_r),
      .err_l(err_l), .err_r(err_r), .fail_vec(fail_vec), .fail_seen(fail_seen),
      .busy(busy), .done(done), .pass(pass)
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- fault-injecting adder models ----------------
   // 0 good, 1 ripple sum bit0 flipped at fault_v, 2 lookahead cout stuck-0,
   // 3 both adders stuck at 0, 4 lookahead sum bit1 flipped at fault_v
   int       fault_mode = 0;
   bit [8:0] fault_v    = '0;

   function automatic bit [4:0] golden(input bit [8:0] v);
      return 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
   endfunction

   function automatic bit [4:0] la_out(input bit [8:0] v);
      bit [4:0] s;
      s = golden(v);
      if (fault_mode == 2) s[4] = 1'b0;
      if (fault_mode == 3) s = '0;
      if (fault_mode == 4 && v == fault_v) s[1] = ~s[1];
      return s;
   endfunction

   function automatic bit [4:0] rp_out(input bit [8:0] v);
      bit [4:0] s;
      s = golden(v);
      if (fault_mode == 3) s = '0;
      if (fault_mode == 1 && v == fault_v) s[0] = ~s[0];
      return s;
   endfunction

   task automatic put(input bit e, input bit [8:0] v);
      en = e;
      {Cin, B, A}     = v;
      {cout_l, sum_l} = la_out(v);
      {cout_r, sum_r} = rp_out(v);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit       valid;
      bit [8:0] v;
      bit [4:0] sl;
      bit [4:0] sr;
   } samp_t;
   typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;

   mmode_t   m_mode = M_IDLE;
   int       m_cnt, m_err_l, m_err_r;
   bit [8:0] m_fail_vec;
   bit       m_fail_seen;
   bit       m_live = 1'b0;
   samp_t    d1, d2, cur;

   task automatic m_clear();
      m_cnt = 0; m_err_l = 0; m_err_r = 0; m_fail_vec = '0; m_fail_seen = 1'b0;
   endtask

   task automatic m_score(input samp_t s);
      int g;
      bit ml, mr;
      g  = int'(s.v[3:0]) + int'(s.v[7:4]) + int'(s.v[8]);
      ml = (int'(s.sl) != g);
      mr = (int'(s.sr) != g);
      m_cnt++;
      if (ml && m_err_l < ERR_MAX) m_err_l++;
      if (mr && m_err_r < ERR_MAX) m_err_r++;
      if (!m_fail_seen && (ml || mr)) begin
         m_fail_seen = 1'b1;
         m_fail_vec  = s.v;
      end
      if (m_cnt == NVEC) m_mode = M_DONE;
`ifdef ADDER_CHK_HALT_ON_ERR_EN
      if (ml || mr) m_mode = M_DONE;
`endif
   endtask

   // A sample taken at edge n starts the sweep at edge n+1 and is scored at edge n+2
   always @(posedge clk) begin
      cur.valid = en;
      cur.v     = {Cin, B, A};
      cur.sl    = {cout_l, sum_l};
      cur.sr    = {cout_r, sum_r};
      if (!reset) begin
         m_mode = M_IDLE;
         m_clear();
         d1 = '{default: 0};
         d2 = '{default: 0};
         m_live = 1'b1;
      end else begin
         if (restart) begin
            m_mode = M_IDLE;
            m_clear();
         end else if (m_mode == M_RUN && d2.valid) begin
            m_score(d2);
         end else if (m_mode == M_IDLE && d1.valid && d1.v == 9'd0) begin
            m_mode = M_RUN;
         end
         d2 = d1;
         d1 = cur;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (m_live) begin
         chk("cyc_err_l", int'(err_l), m_err_l);
         chk("cyc_err_r", int'(err_r), m_err_r);
         chk("cyc_fail_vec", int'(fail_vec), int'(m_fail_vec));
         chk("cyc_fail_seen", int'(fail_seen), int'(m_fail_seen));
         chk("cyc_busy", int'(busy), int'(m_mode == M_RUN));
         chk("cyc_done", int'(done), int'(m_mode == M_DONE));
         chk("cyc_pass", int'(pass), int'(m_mode == M_DONE && m_err_l == 0 && m_err_r == 0));
      end
   end

   // ---------------- stimulus ----------------
   int it_v0, it_busy, it_last, it_fault, it_done;

   // Each iteration: observe, drive one counter value (or a gap), advance one edge
   task automatic sweep(input bit [8:0] start, input int gap_at, input int gap_len,
                        input int max_cyc, input bit want_done, output bit [8:0] v_next);
      bit [8:0] v = start;
      int issued = 0;
      int gap_left = gap_len;
      it_v0 = -1; it_busy = -1; it_last = -1; it_fault = -1; it_done = -1;
      for (int i = 0; i < max_cyc; i++) begin
         if (want_done && done) begin
            it_done = i;
            break;
         end
         if (it_v0 >= 0 && it_busy < 0 && busy) it_busy = i;
         if (issued == gap_at && gap_left > 0) begin
            put(1'b0, v);
            gap_left--;
         end else begin
            put(1'b1, v);
            if (v == 9'd0 && it_v0 < 0) it_v0 = i;
            if (v == 9'h1FF) it_last = i;
            if (v == fault_v) it_fault = i;
            v = v + 9'd1;
            issued++;
         end
         @(posedge clk); #1;
      end
      if (want_done && it_done < 0) chk("sweep_timeout", 0, 1);
      put(1'b0, v);
      v_next = v;
   endtask

   task automatic do_restart();
      put(1'b0, 9'd0);
      restart = 1'b1;
      @(posedge clk); #1;
      restart = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [8:0] vn;
      int fm, gat, glen;
      reset = 1'b0; restart = 1'b0;
      put(1'b0, 9'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_err_l", int'(err_l), 0);
      chk("rst_err_r", int'(err_r), 0);
      chk("rst_fail_vec", int'(fail_vec), 0);
      chk("rst_fail_seen", int'(fail_seen), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pass", int'(pass), 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Correct adders, full sweep from 0
      fault_mode = 0; fault_v = 9'h1FF;
      sweep(9'd0, -1, 0, 700, 1'b1, vn);
      chk("t1_busy_lat", it_busy - it_v0, 2);
      chk("t1_done_lat", it_done - it_last, 3);
      chk("t1_err_l", int'(err_l), 0);
      chk("t1_err_r", int'(err_r), 0);
      chk("t1_fail_seen", int'(fail_seen), 0);
      chk("t1_pass", int'(pass), 1);
      do_restart();
      chk("t1_restart_done", int'(done), 0);
      chk("t1_restart_busy", int'(busy), 0);

      // Ripple single-vector fault at 0A5
      fault_mode = 1; fault_v = 9'h0A5;
      sweep(9'd0, -1, 0, 700, 1'b1, vn);
      chk("t2_err_l", int'(err_l), 0);
      chk("t2_err_r", int'(err_r), 1);
      chk("t2_fail_vec", int'(fail_vec), 'h0A5);
      chk("t2_pass", int'(pass), 0);
`ifdef ADDER_CHK_HALT_ON_ERR_EN
      chk("t2_halt_lat", it_done - it_fault, 3);
`else
      chk("t2_done_lat", it_done - it_last, 3);
`endif
      do_restart();

      // Lookahead carry stuck-0: 256 carry vectors, first at 01F
      fault_mode = 2; fault_v = 9'h1FF;
      sweep(9'd0, -1, 0, 700, 1'b1, vn);
`ifdef ADDER_CHK_HALT_ON_ERR_EN
      chk("t3_err_l", int'(err_l), 1);
`else
      chk("t3_err_l", int'(err_l), 255);
`endif
      chk("t3_err_r", int'(err_r), 0);
      chk("t3_fail_vec", int'(fail_vec), 'h01F);
      do_restart();

      // Both adders stuck at 0: 511 mismatches each, saturating
      fault_mode = 3;
      sweep(9'd0, -1, 0, 700, 1'b1, vn);
`ifdef ADDER_CHK_HALT_ON_ERR_EN
      chk("t4_err_l", int'(err_l), 1);
      chk("t4_err_r", int'(err_r), 1);
`else
      chk("t4_err_l", int'(err_l), 255);
      chk("t4_err_r", int'(err_r), 255);
`endif
      chk("t4_fail_vec", int'(fail_vec), 'h001);
      do_restart();

      // Start mid-count at 050, en low for 20 cycles mid-sweep
      fault_mode = 0;
      sweep(9'h050, 400, 20, 1200, 1'b1, vn);
      chk("t5_busy_lat", it_busy - it_v0, 2);
      chk("t5_pass", int'(pass), 1);
      do_restart();

      // Reset at vector 300 with a fault already counted, then a clean sweep
      fault_mode = 1; fault_v = 9'h0A5;
      sweep(9'd0, -1, 0, 301, 1'b0, vn);
      chk("t6_pre_err_r", int'(err_r), 1);
      reset = 1'b0;
      put(1'b1, vn);
      @(posedge clk); #1;
      reset = 1'b1;
      chk("t6_err_r", int'(err_r), 0);
      chk("t6_fail_vec", int'(fail_vec), 0);
      chk("t6_fail_seen", int'(fail_seen), 0);
      chk("t6_busy", int'(busy), 0);
      chk("t6_done", int'(done), 0);
      fault_mode = 0;
      sweep(vn + 9'd1, -1, 0, 1200, 1'b1, vn);
      chk("t6_pass", int'(pass), 1);
      do_restart();

      // Randomized start, gap and single-vector fault on either adder
      for (int k = 0; k < 3; k++) begin
         fm         = ($urandom_range(0, 1) == 0) ? 1 : 4;
         fault_mode = fm;
         fault_v    = 9'($urandom_range(0, 511));
         gat        = int'($urandom_range(0, 500));
         glen       = int'($urandom_range(1, 30));
         sweep(9'($urandom_range(0, 511)), gat, glen, 1300, 1'b1, vn);
         chk("rnd_err_l", int'(err_l), (fm == 4) ? 1 : 0);
         chk("rnd_err_r", int'(err_r), (fm == 1) ? 1 : 0);
         chk("rnd_fail_vec", int'(fail_vec), int'(fault_v));
         chk("rnd_pass", int'(pass), 0);
         do_restart();
      end

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
